idu_burst: RTL and testbench
============================

IDU_BURST -- requirements
Module: idu_burst

Interface
REQ-001 SHALL have parameter WIDTH, default 2*DATA_WIDTH (16), pointer/address width.
REQ-002 SHALL have parameter NUM_PTR, default 4, number of pointer registers.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of burst step count.
REQ-004 SHALL have port clk  input  1  system clock (4 MHz); the only clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port phi  input  1  M-cycle strobe, one clk wide, 1 in 4 clks.
REQ-007 SHALL have port req_valid  input  1  request offered.
REQ-008 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_op  input  idu_ops_t  operation: IDU_NOP, INC16, DEC16, PASS16, LD16.
REQ-010 SHALL have port req_sel  input  $clog2(NUM_PTR)  target pointer index.
REQ-011 SHALL have port req_operand  input  WIDTH  load value for LD16.
REQ-012 SHALL have port req_count  input  CNT_WIDTH  INC16/DEC16 step count; 0 treated as 1.
REQ-013 SHALL have port flush  input  1  abort current burst.
REQ-014 SHALL have port res_valid  output  1  one-clk pulse per executed step.
REQ-015 SHALL have port res_addr  output  WIDTH  pre-operation pointer value (address-bus value).
REQ-016 SHALL have port res_last  output  1  final step of request, qualified by res_valid.
REQ-017 SHALL have port res_wrap  output  1  step wrapped (max->0 or 0->max), qualified by res_valid.
REQ-018 SHALL have port ptr_rd_sel / ptr_rd_data  input $clog2(NUM_PTR) / output WIDTH  combinational pointer read port.
REQ-019 SHALL have port oam_bug  output  1  OAM-corruption trigger (see Configuration).
REQ-020 SHALL have port busy  output  1  high in state BUSY.

Function
REQ-021 SHALL implement states IDLE and BUSY; req_ready = (state==IDLE), combinational.
REQ-022 SHALL, on clk with req_valid&&req_ready&&!flush, latch op/sel/operand/count and enter BUSY; IDU_NOP is accepted and dropped, staying IDLE.
REQ-023 SHALL execute steps only on clk with phi high while BUSY; acceptance clk with phi high does not execute a step (first step at next phi).
REQ-024 SHALL, per INC16/DEC16 step: res_addr = ptr[sel] (pre), ptr[sel] <= ptr[sel] +/- 1 mod 2^WIDTH, res_valid=1, remaining count decremented.
REQ-025 SHALL assert res_last and return to IDLE on the step where remaining reaches 0.
REQ-026 SHALL execute LD16 as one step: ptr[sel] <= operand, res_addr = operand, res_last=1, res_wrap=0.
REQ-027 SHALL execute PASS16 as one step: res_addr = ptr[sel], no write-back, res_last=1.
REQ-028 SHALL treat req_sel >= NUM_PTR as PASS16 returning res_addr=0, no write-back.
REQ-029 SHALL register res_* outputs: valid the clk after the phi step, low otherwise.
REQ-030 SHALL, on flush, enter IDLE next clk; flush coincident with phi executes no step; flush beats req_valid.
REQ-031 SHALL make ptr_rd_data reflect write-back from the clk following the step clk.

Reset
REQ-032 SHALL, while rst_n low: state IDLE, all ptr 0, res_valid/res_last/res_wrap/res_addr/oam_bug/busy 0; requests ignored.
REQ-033 SHALL abandon any burst on reset mid-operation; no further res_valid.

Configuration
REQ-034 SHALL, with IDU_OAM_BUG_EN defined, pulse oam_bug with res_valid when op is INC16/DEC16 and pre-value bits[15:8]==8'hFE.
REQ-035 SHALL, without IDU_OAM_BUG_EN, keep port oam_bug and tie it to 0.

Structure
REQ-036 SHALL place idu_ops_t (extended), idu_state_t and OAM_PAGE (8'hFE) in gate_boy_pkg.
REQ-037 SHALL use sub-module idu_step: combinational WIDTH-bit +/-1 with wrap flag.

Verification
REQ-038 Reset, INC16 sel=0 count=3 -> three res_valid at successive phi: addr 0000,0001,0002; last on third; ptr0=0003.
REQ-039 LD16 sel=1 FFFF, then INC16 sel=1 count=1 -> res_addr FFFF, res_wrap=1, ptr1=0000.
REQ-040 DEC16 sel=2 count=0 from 0000 -> one step, addr 0000, wrap=1, last=1, ptr2=FFFF.
REQ-041 INC16 count=10, flush after 2nd step coincident with phi -> exactly 2 res_valid, ptr=0002, req_ready next clk.
REQ-042 LD16 FE10 then INC16 -> oam_bug=1 with IDU_OAM_BUG_EN, 0 without; rst_n low mid-burst -> ptrs 0, no res_valid.

Source files
------------

// File: rtl/gate_boy_pkg.sv
// Shared types and constants for the address increment/decrement unit (IDU).
package gate_boy_pkg;

    localparam int DATA_WIDTH = 8;
    localparam logic [7:0] OAM_PAGE = 8'hFE;

    typedef enum logic [2:0] {
        IDU_NOP = 3'd0,
        INC16   = 3'd1,
        DEC16   = 3'd2,
        PASS16  = 3'd3,
        LD16    = 3'd4
    } idu_ops_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } idu_state_t;

    function automatic logic is_step_op(input idu_ops_t op);
        return (op == INC16) || (op == DEC16);
    endfunction

    function automatic logic is_oam_page(input logic [7:0] hi);
        return hi == OAM_PAGE;
    endfunction

endpackage

// File: rtl/idu_step.sv
// Combinational WIDTH-bit increment/decrement with wrap detection.
module idu_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_y,
    output logic             o_wrap
);

    assign o_y    = i_dec ? (i_a - WIDTH'(1)) : (i_a + WIDTH'(1));
    assign o_wrap = i_dec ? (i_a == '0) : (i_a == '1);

endmodule

// File: rtl/idu_burst.sv
// Pointer-register IDU executing INC16/DEC16 bursts, LD16 and PASS16, one step per phi.
// Define IDU_OAM_BUG_EN to drive oam_bug; otherwise the port is tied low.
module idu_burst
    import gate_boy_pkg::*;
#(
    parameter int WIDTH     = 2 * DATA_WIDTH,
    parameter int NUM_PTR   = 4,
    parameter int CNT_WIDTH = 8,
    localparam int SEL_W    = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 phi,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  idu_ops_t             req_op,
    input  logic [SEL_W-1:0]     req_sel,
    input  logic [WIDTH-1:0]     req_operand,
    input  logic [CNT_WIDTH-1:0] req_count,
    input  logic                 flush,
    output logic                 res_valid,
    output logic [WIDTH-1:0]     res_addr,
    output logic                 res_last,
    output logic                 res_wrap,
    input  logic [SEL_W-1:0]     ptr_rd_sel,
    output logic [WIDTH-1:0]     ptr_rd_data,
    output logic                 oam_bug,
    output logic                 busy
);

    idu_state_t           r_state;
    idu_state_t           w_state_nxt;
    idu_ops_t             r_op;
    logic [SEL_W-1:0]     r_sel;
    logic [WIDTH-1:0]     r_operand;
    logic [CNT_WIDTH-1:0] r_rem;
    logic [WIDTH-1:0]     r_ptr [NUM_PTR];

    logic                 r_res_valid;
    logic                 r_res_last;
    logic                 r_res_wrap;
    logic [WIDTH-1:0]     r_res_addr;

    logic                 w_accept;
    logic                 w_step;
    logic                 w_sel_ok;
    logic                 w_rd_ok;
    idu_ops_t             w_op_eff;
    logic [WIDTH-1:0]     w_pre;
    logic [WIDTH-1:0]     w_post;
    logic                 w_wrap;
    logic                 w_last;
    logic                 w_wb_en;
    logic [WIDTH-1:0]     w_wb;
    logic [WIDTH-1:0]     w_res_addr;
    logic                 w_res_wrap;

    // Out-of-range selects only exist when NUM_PTR is not a power of two.
    generate
        if ((1 << SEL_W) > NUM_PTR) begin : g_sel_chk
            assign w_sel_ok = (r_sel < SEL_W'(NUM_PTR));
            assign w_rd_ok  = (ptr_rd_sel < SEL_W'(NUM_PTR));
        end else begin : g_sel_full
            assign w_sel_ok = 1'b1;
            assign w_rd_ok  = 1'b1;
        end
    endgenerate

    assign w_accept    = (r_state == IDLE) && req_valid && !flush;
    assign w_step      = (r_state == BUSY) && phi && !flush;
    assign w_op_eff    = w_sel_ok ? r_op : PASS16;
    assign w_pre       = w_sel_ok ? r_ptr[r_sel] : '0;
    assign req_ready   = (r_state == IDLE);
    assign busy        = (r_state == BUSY);
    assign ptr_rd_data = w_rd_ok ? r_ptr[ptr_rd_sel] : '0;

    idu_step #(.WIDTH(WIDTH)) u_step (
        .i_a    (w_pre),
        .i_dec  (r_op == DEC16),
        .o_y    (w_post),
        .o_wrap (w_wrap)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_last      = 1'b1;
        w_wb_en     = 1'b0;
        w_wb        = w_post;
        w_res_addr  = w_pre;
        w_res_wrap  = 1'b0;

        if (is_step_op(w_op_eff)) begin
            w_last     = (r_rem == CNT_WIDTH'(1));
            w_wb_en    = 1'b1;
            w_res_wrap = w_wrap;
        end else if (w_op_eff == LD16) begin
            w_wb_en    = 1'b1;
            w_wb       = r_operand;
            w_res_addr = r_operand;
        end

        if (r_state == IDLE) begin
            if (w_accept && (req_op != IDU_NOP)) w_state_nxt = BUSY;
        end else if (flush || (w_step && w_last)) begin
            w_state_nxt = IDLE;
        end
    end

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= IDU_NOP;
            r_sel       <= '0;
            r_operand   <= '0;
            r_rem       <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            r_res_wrap  <= 1'b0;
            r_res_addr  <= '0;
            // NOTE: the pointer file is architectural state that must read 0 after reset, so it is reset like any flop.
            for (int i = 0; i < NUM_PTR; i++) r_ptr[i] <= '0;
        end else begin
            r_res_valid <= w_step;
            r_res_last  <= w_step && w_last;
            r_res_wrap  <= w_step && w_res_wrap;
            r_res_addr  <= w_step ? w_res_addr : '0;

            if (w_accept) begin
                r_op      <= req_op;
                r_sel     <= req_sel;
                r_operand <= req_operand;
                r_rem     <= (req_count == '0) ? CNT_WIDTH'(1) : req_count;
            end else if (w_step) begin
                r_rem <= r_rem - CNT_WIDTH'(1);
            end

            if (w_step && w_wb_en) r_ptr[r_sel] <= w_wb;
        end
    end

    assign res_valid = r_res_valid;
    assign res_last  = r_res_last;
    assign res_wrap  = r_res_wrap;
    assign res_addr  = r_res_addr;

`ifdef IDU_OAM_BUG_EN
    logic r_oam_bug;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_oam_bug <= 1'b0;
        else        r_oam_bug <= w_step && is_step_op(w_op_eff) && is_oam_page(w_pre[15:8]);
    end

    assign oam_bug = r_oam_bug;
`else
    assign oam_bug = 1'b0;
`endif

endmodule

// File: tb/tb_idu_burst.sv
// Self-checking bench for idu_burst: directed scenarios plus random requests against an arithmetic model.
`timescale 1ns/1ps
module tb_idu_burst;
    import gate_boy_pkg::*;

`ifdef IDU_OAM_BUG_EN
    localparam bit OAM_EN = 1'b1;
`else
    localparam bit OAM_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic        last;
        logic        wrap;
        logic        oam;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phi = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    idu_ops_t    req_op = IDU_NOP;
    logic [1:0]  req_sel = '0;
    logic [15:0] req_operand = '0;
    logic [7:0]  req_count = '0;
    logic        flush = 1'b0;
    logic        res_valid;
    logic [15:0] res_addr;
    logic        res_last;
    logic        res_wrap;
    logic [1:0]  ptr_rd_sel = '0;
    logic [15:0] ptr_rd_data;
    logic        oam_bug;
    logic        busy;

    idu_burst #(.WIDTH(16), .NUM_PTR(4), .CNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phi         (phi),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_sel     (req_sel),
        .req_operand (req_operand),
        .req_count   (req_count),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_addr    (res_addr),
        .res_last    (res_last),
        .res_wrap    (res_wrap),
        .ptr_rd_sel  (ptr_rd_sel),
        .ptr_rd_data (ptr_rd_data),
        .oam_bug     (oam_bug),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   phase = 0;
    int   tcount = 0;
    int   accept_t = 0;
    int   m_ptr [4];
    res_t obs_q [$];
    int   obs_t [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, log any result pulse, then set phi for the coming rising edge.
    task automatic tick();
        @(negedge clk);
        tcount++;
        if (res_valid === 1'b1) begin
            check("step_on_phi", phi, 1'b1);
            obs_q.push_back('{res_addr, res_last, res_wrap, oam_bug});
            obs_t.push_back(tcount);
        end
        phi   = (phase == 3);
        phase = (phase + 1) % 4;
    endtask

    task automatic check_ptrs();
        for (int i = 0; i < 4; i++) begin
            ptr_rd_sel = 2'(i);
            #1;
            check("ptr_rd_data", ptr_rd_data, 32'(m_ptr[i]));
        end
    endtask

    task automatic send(input idu_ops_t op, input logic [1:0] sel, input logic [15:0] operand,
                        input logic [7:0] count);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("req_ready_before", req_ready, 1'b1);
        req_valid   = 1'b1;
        req_op      = op;
        req_sel     = sel;
        req_operand = operand;
        req_count   = count;
        tick();
        accept_t    = tcount;
        req_valid   = 1'b0;
        req_op      = IDU_NOP;
        req_sel     = 2'($urandom);
        req_operand = 16'($urandom);
        req_count   = 8'($urandom);
        check("busy_after_accept", busy, op != IDU_NOP);
    endtask

    // Expected results come from the operation rules: step k of a burst reads start +/- k.
    task automatic run_req(input idu_ops_t op, input logic [1:0] sel, input logic [15:0] operand,
                           input logic [7:0] count, input int exp_lat);
        res_t exp_q [$];
        int   n;
        int   start;
        int   guard;
        start = m_ptr[sel];
        n = 0;
        if (op == INC16 || op == DEC16) begin
            n = (count == 0) ? 1 : int'(count);
            for (int k = 0; k < n; k++) begin
                int a;
                a = ((op == INC16) ? start + k : start - k) & 32'hFFFF;
                exp_q.push_back('{addr: 16'(a), last: (k == n - 1),
                                  wrap: (op == INC16) ? (a == 32'hFFFF) : (a == 0),
                                  oam:  OAM_EN && ((a >> 8) == 32'hFE)});
            end
            m_ptr[sel] = ((op == INC16) ? start + n : start - n) & 32'hFFFF;
        end else if (op == LD16) begin
            n = 1;
            exp_q.push_back('{addr: operand, last: 1'b1, wrap: 1'b0, oam: 1'b0});
            m_ptr[sel] = int'(operand);
        end else if (op == PASS16) begin
            n = 1;
            exp_q.push_back('{addr: 16'(start), last: 1'b1, wrap: 1'b0, oam: 1'b0});
        end

        obs_q.delete();
        obs_t.delete();
        send(op, sel, operand, count);
        guard = 0;
        while (obs_q.size() < n && guard < 4 * n + 12) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 5; i++) tick();

        check("res_count", obs_q.size(), n);
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            check("res_addr", obs_q[i].addr, exp_q[i].addr);
            check("res_last", obs_q[i].last, exp_q[i].last);
            check("res_wrap", obs_q[i].wrap, exp_q[i].wrap);
            check("oam_bug",  obs_q[i].oam,  exp_q[i].oam);
            if (i == 0) begin
                check("first_lat_range", (obs_t[0] - accept_t >= 1) && (obs_t[0] - accept_t <= 4), 1'b1);
                if (exp_lat > 0) check("first_lat", obs_t[0] - accept_t, exp_lat);
            end else begin
                check("step_spacing", obs_t[i] - obs_t[i-1], 4);
            end
        end
        check("req_ready_done", req_ready, 1'b1);
        check("busy_done", busy, 1'b0);
        check_ptrs();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4; i++) m_ptr[i] = 0;

        // Reset state
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_op = INC16;
        for (int i = 0; i < 6; i++) tick();
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_addr",  res_addr,  16'h0);
        check("rst_res_last",  res_last,  1'b0);
        check("rst_res_wrap",  res_wrap,  1'b0);
        check("rst_oam_bug",   oam_bug,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check_ptrs();
        req_valid = 1'b0;
        req_op = IDU_NOP;
        rst_n = 1'b1;
        tick();

        // Basic burst and boundary cases
        run_req(INC16, 2'd0, 16'h0, 8'd3, -1);
        run_req(LD16,  2'd1, 16'hFFFF, 8'd0, -1);
        run_req(INC16, 2'd1, 16'h0, 8'd1, -1);
        run_req(DEC16, 2'd2, 16'h0, 8'd0, -1);
        run_req(PASS16, 2'd0, 16'h0, 8'd0, -1);
        run_req(IDU_NOP, 2'd3, 16'h1234, 8'd2, -1);

        // Acceptance on a phi edge must not itself execute a step
        guard = 0;
        while (phi !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        run_req(DEC16, 2'd0, 16'h0, 8'd2, 4);

        // Flush after the second step, coincident with phi
        obs_q.delete();
        obs_t.delete();
        send(INC16, 2'd3, 16'h0, 8'd10);
        guard = 0;
        while (obs_q.size() < 2 && guard < 20) begin
            tick();
            guard++;
        end
        guard = 0;
        while (phi !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_req_ready", req_ready, 1'b1);
        check("flush_busy", busy, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("flush_res_count", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            check("flush_addr0", obs_q[0].addr, 16'h0000);
            check("flush_addr1", obs_q[1].addr, 16'h0001);
            check("flush_last1", obs_q[1].last, 1'b0);
        end
        m_ptr[3] = 2;
        check_ptrs();

        // Flush beats a simultaneous request
        obs_q.delete();
        req_valid = 1'b1;
        req_op = INC16;
        req_sel = 2'd3;
        req_count = 8'd1;
        flush = 1'b1;
        tick();
        req_valid = 1'b0;
        req_op = IDU_NOP;
        flush = 1'b0;
        check("flush_vs_req_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("flush_vs_req_pulses", obs_q.size(), 0);
        check_ptrs();

        // OAM page trigger
        run_req(LD16,  2'd0, 16'hFE10, 8'd0, -1);
        run_req(INC16, 2'd0, 16'h0, 8'd2, -1);
        run_req(LD16,  2'd2, 16'hFF00, 8'd0, -1);
        run_req(DEC16, 2'd2, 16'h0, 8'd2, -1);

        // Random requests
        for (int it = 0; it < 24; it++) begin
            int          r;
            idu_ops_t    op;
            logic [1:0]  sel;
            logic [15:0] val;
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 3))
                    0:       val = 16'hFFFE;
                    1:       val = 16'h0001;
                    2:       val = 16'hFDFF;
                    default: val = 16'($urandom);
                endcase
                run_req(LD16, sel, val, 8'd0, -1);
            end
            r = $urandom_range(0, 9);
            op = (r < 4) ? INC16 : (r < 7) ? DEC16 : (r < 8) ? LD16 : (r < 9) ? PASS16 : IDU_NOP;
            run_req(op, sel, 16'($urandom), 8'($urandom_range(0, 5)), -1);
        end

        // Reset in the middle of a burst
        run_req(LD16, 2'd2, 16'h1234, 8'd0, -1);
        obs_q.delete();
        obs_t.delete();
        send(INC16, 2'd2, 16'h0, 8'd8);
        guard = 0;
        while (obs_q.size() < 1 && guard < 12) begin
            tick();
            guard++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_oam", oam_bug, 1'b0);
        for (int i = 0; i < 4; i++) m_ptr[i] = 0;
        check_ptrs();
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("midrst_pulses", obs_q.size(), 1);
        check("midrst_busy_after", busy, 1'b0);
        check_ptrs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
